// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - frame parser and payload buffer behind a UART receiver
//
// Hunts for SYNC_BYTE, then parses ADDR, LEN, LEN payload bytes and CSUM,
// where CSUM = XOR(ADDR, LEN, payload). Verified payloads are drained on a
// valid/ready byte stream. Errors and dropped bytes are reported as
// registered one-cycle pulses.
//
// Ports:
//   clk          clock, rising edge
//   r_reset      synchronous active-high reset
//   i_rx_valid   one-cycle byte-ready pulse from the receiver
//   i_rx_data    received byte
//   o_valid      payload byte available downstream
//   i_ready      downstream accept
//   o_data       payload byte
//   o_last       final payload byte of the frame
//   o_addr       latched ADDR byte
//   o_len        latched LEN byte
//   o_frame_ok   pulse: frame verified
//   o_frame_err  pulse: frame discarded
//   o_err_code   1=LEN too large, 2=checksum mismatch, 3=timeout
//   o_overrun    pulse: byte dropped while draining
//   o_busy       controller is not hunting for sync

module uart_rx_frame_ctrl #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 436240
) (
    input  logic       clk,
    input  logic       r_reset,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic [7:0] o_addr,
    output logic [7:0] o_len,
    output logic       o_frame_ok,
    output logic       o_frame_err,
    output logic [1:0] o_err_code,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int IW = $clog2(MAX_LEN + 1);
    // Buffer address width; idx never exceeds MAX_LEN-1 while writing.
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE   = TW'(1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_ADDR    = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] idx, idx_next;
    logic [IW-1:0] rd_idx, rd_idx_next;
    logic [7:0]    xor_q, xor_next;
    logic [7:0]    addr_q, addr_next;
    logic [7:0]    len_q, len_next;
    logic [TW-1:0] tmo, tmo_next;
    logic          wr_en;
    logic          ok_next, err_next, ovr_next;
    logic [1:0]    code_next;
    logic          timed;
    logic          last_byte;

    logic [7:0] pbuf [0:MAX_LEN-1];

    // Only the header/payload/checksum phases are watched for stalls.
    assign timed = (state == S_ADDR) || (state == S_LEN) ||
                   (state == S_PAYLOAD) || (state == S_CSUM);

    assign last_byte = (8'(rd_idx) == (len_q - 8'd1));

    assign o_valid = (state == S_DRAIN);
    assign o_last  = (state == S_DRAIN) && last_byte;
    assign o_data  = (state == S_DRAIN) ? pbuf[rd_idx[AW-1:0]] : 8'h00;
    assign o_addr  = addr_q;
    assign o_len   = len_q;
    assign o_busy  = (state != S_HUNT);

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        rd_idx_next = rd_idx;
        xor_next    = xor_q;
        addr_next   = addr_q;
        len_next    = len_q;
        wr_en       = 1'b0;
        ok_next     = 1'b0;
        err_next    = 1'b0;
        code_next   = 2'd0;
        ovr_next    = 1'b0;

        case (state)
            S_HUNT: begin
                if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (i_rx_valid) begin
                    addr_next  = i_rx_data;
                    xor_next   = i_rx_data;
                    state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (i_rx_valid) begin
                    len_next = i_rx_data;
                    xor_next = xor_q ^ i_rx_data;
                    idx_next = '0;
                    if (i_rx_data > MAX_LEN_B) begin
                        state_next = S_HUNT;
                        err_next   = 1'b1;
                        code_next  = 2'd1;
                    end else if (i_rx_data == 8'd0) begin
                        state_next = S_CSUM;
                    end else begin
                        state_next = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_rx_valid) begin
                    wr_en    = 1'b1;
                    xor_next = xor_q ^ i_rx_data;
                    if (8'(idx) == (len_q - 8'd1)) begin
                        idx_next   = '0;
                        state_next = S_CSUM;
                    end else begin
                        idx_next = idx + IDX_ONE;
                    end
                end
            end
            S_CSUM: begin
                if (i_rx_valid) begin
                    if (i_rx_data == xor_q) begin
                        ok_next    = 1'b1;
                        state_next = (len_q != 8'd0) ? S_DRAIN : S_HUNT;
                    end else begin
                        err_next   = 1'b1;
                        code_next  = 2'd2;
                        state_next = S_HUNT;
                    end
                end
            end
            S_DRAIN: begin
                // No backpressure upstream: anything arriving now is lost.
                ovr_next = i_rx_valid;
                if (i_ready) begin
                    if (last_byte) begin
                        rd_idx_next = '0;
                        state_next  = S_HUNT;
                    end else begin
                        rd_idx_next = rd_idx + IDX_ONE;
                    end
                end
            end
            default: begin
                state_next = S_HUNT;
            end
        endcase

        // A byte in the expiry cycle takes priority over the timeout.
        if (timed && (tmo == TMO_LAST) && !i_rx_valid) begin
            state_next = S_HUNT;
            idx_next   = '0;
            err_next   = 1'b1;
            code_next  = 2'd3;
        end

        if (!timed || i_rx_valid || (state_next != state)) begin
            tmo_next = '0;
        end else begin
            tmo_next = tmo + TMO_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (r_reset) begin
            state       <= S_HUNT;
            idx         <= '0;
            rd_idx      <= '0;
            xor_q       <= 8'h00;
            addr_q      <= 8'h00;
            len_q       <= 8'h00;
            tmo         <= '0;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
            o_err_code  <= 2'd0;
            o_overrun   <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            rd_idx      <= rd_idx_next;
            xor_q       <= xor_next;
            addr_q      <= addr_next;
            len_q       <= len_next;
            tmo         <= tmo_next;
            o_frame_ok  <= ok_next;
            o_frame_err <= err_next;
            o_err_code  <= code_next;
            o_overrun   <= ovr_next;
        end
    end

    // Payload storage carries no reset; contents are overwritten per frame.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pbuf[idx[AW-1:0]] <= i_rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - directed self-checking bench for uart_rx_frame_ctrl

module tb_uart_rx_frame_ctrl;

    logic       clk;
    logic       r_reset;
    logic       i_rx_valid;
    logic [7:0] i_rx_data;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_last;
    logic [7:0] o_addr;
    logic [7:0] o_len;
    logic       o_frame_ok;
    logic       o_frame_err;
    logic [1:0] o_err_code;
    logic       o_overrun;
    logic       o_busy;

    int n_cmp;
    int n_bad;

    uart_rx_frame_ctrl #(
        .MAX_LEN(16),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .r_reset(r_reset),
        .i_rx_valid(i_rx_valid),
        .i_rx_data(i_rx_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data(o_data),
        .o_last(o_last),
        .o_addr(o_addr),
        .o_len(o_len),
        .o_frame_ok(o_frame_ok),
        .o_frame_err(o_frame_err),
        .o_err_code(o_err_code),
        .o_overrun(o_overrun),
        .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives and samples both happen 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle after the sampling edge, where pulses are visible.
    task automatic send(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        tick();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        r_reset    = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        i_ready    = 1'b1;
        tick();
        tick();
        r_reset = 1'b0;

        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_len", o_len, 0);
        chk("rst_ok", o_frame_ok, 0);
        chk("rst_err", {o_frame_err, o_err_code}, 0);

        // Good frame, streaming at full rate
        send(8'hA5); send(8'h12); send(8'h03);
        send(8'h01); send(8'h02); send(8'h03);
        send(8'h11);
        chk("g_ok", o_frame_ok, 1);
        chk("g_v0", o_valid, 1);
        chk("g_d0", o_data, 8'h01);
        chk("g_l0", o_last, 0);
        chk("g_addr", o_addr, 8'h12);
        chk("g_len", o_len, 8'h03);
        tick();
        chk("g_ok_once", o_frame_ok, 0);
        chk("g_d1", o_data, 8'h02);
        chk("g_l1", o_last, 0);
        tick();
        chk("g_d2", o_data, 8'h03);
        chk("g_l2", o_last, 1);
        tick();
        chk("g_done_valid", o_valid, 0);
        chk("g_done_busy", o_busy, 0);

        // Checksum mismatch, then a good frame
        send(8'hA5); send(8'h12); send(8'h03);
        send(8'h01); send(8'h02); send(8'h03);
        send(8'h10);
        chk("cs_err", {o_frame_err, o_err_code}, {1'b1, 2'd2});
        chk("cs_valid", o_valid, 0);
        chk("cs_ok", o_frame_ok, 0);
        tick();
        chk("cs_err_once", {o_frame_err, o_err_code}, 0);
        chk("cs_valid2", o_valid, 0);
        send(8'hA5); send(8'h12); send(8'h03);
        send(8'h01); send(8'h02); send(8'h03);
        send(8'h11);
        chk("cs_next_ok", o_frame_ok, 1);
        tick(); tick(); tick();
        chk("cs_next_idle", o_busy, 0);

        // Oversize LEN
        send(8'hA5); send(8'h12); send(8'h20);
        chk("len_err", {o_frame_err, o_err_code}, {1'b1, 2'd1});
        chk("len_busy", o_busy, 0);
        send(8'h00); send(8'h12); send(8'h33);
        chk("len_ignore_busy", o_busy, 0);
        chk("len_ignore_err", o_frame_err, 0);

        // Timeout fires 100 cycles after the ADDR byte
        send(8'hA5); send(8'h12);
        for (int i = 0; i < 99; i++) tick();
        chk("tmo_early", o_frame_err, 0);
        chk("tmo_early_busy", o_busy, 1);
        tick();
        chk("tmo_err", {o_frame_err, o_err_code}, {1'b1, 2'd3});
        chk("tmo_busy", o_busy, 0);

        // Byte in the expiry cycle wins; LEN=0 frame then completes
        send(8'hA5); send(8'h12);
        for (int i = 0; i < 99; i++) tick();
        send(8'h00);
        chk("tmo_win_err", o_frame_err, 0);
        chk("tmo_win_busy", o_busy, 1);
        send(8'h12);
        chk("len0_ok", o_frame_ok, 1);
        chk("len0_busy", o_busy, 0);
        chk("len0_valid", o_valid, 0);

        // Backpressure with a byte injected mid-drain
        i_ready = 1'b0;
        send(8'hA5); send(8'h12); send(8'h03);
        send(8'h01); send(8'h02); send(8'h03);
        send(8'h11);
        chk("bp_ok", o_frame_ok, 1);
        chk("bp_d0", o_data, 8'h01);
        for (int i = 0; i < 5; i++) tick();
        send(8'hA5);
        chk("bp_ovr", o_overrun, 1);
        chk("bp_hold", o_data, 8'h01);
        for (int i = 0; i < 13; i++) tick();
        chk("bp_ovr_once", o_overrun, 0);
        chk("bp_hold2", o_data, 8'h01);
        chk("bp_hold_v", o_valid, 1);
        i_ready = 1'b1;
        chk("bp_d0b", o_data, 8'h01);
        tick();
        chk("bp_d1", o_data, 8'h02);
        tick();
        chk("bp_d2", {o_last, o_data}, {1'b1, 8'h03});
        tick();
        chk("bp_idle", {o_valid, o_busy}, 0);

        // Preamble, double sync, reset mid-payload
        send(8'h00); send(8'hFF);
        chk("pre_busy", o_busy, 0);
        send(8'hA5);
        chk("pre_sync", o_busy, 1);
        send(8'hA5);
        chk("pre_addr", o_addr, 8'hA5);
        send(8'h03); send(8'h01);
        chk("pre_len", o_len, 8'h03);
        r_reset = 1'b1;
        tick();
        r_reset = 1'b0;
        chk("mrst_outs", {o_valid, o_busy, o_addr, o_len}, 0);
        chk("mrst_pulses", {o_frame_ok, o_frame_err, o_err_code, o_overrun}, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("mrst_quiet", {o_frame_ok, o_frame_err, o_overrun, o_busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame-level controller that sits directly behind the UART receiver and sequences its byte stream into framed packets. It consumes the receiver's one-cycle byte-ready pulses, hunts for a sync byte, parses address, length, payload and checksum, and buffers the payload. Only verified frames are released downstream on a valid/ready byte stream. Bad, oversize and stalled frames are discarded and reported.

Parameters:
MAX_LEN, 16, payload buffer depth in bytes; legal LEN range is 0..MAX_LEN
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 436240, maximum idle cycles allowed between bytes inside a frame (two byte-times at 21812 cycles/bit)

Ports:
clk  input  1  clock, all logic on rising edge
r_reset  input  1  reset; synchronous, active-high
i_rx_valid  input  1  one-cycle pulse when a received byte is available (receiver ready-to-read)
i_rx_data  input  8  received byte, valid when i_rx_valid=1
o_valid  output  1  payload byte available downstream
i_ready  input  1  downstream accepts byte when o_valid&&i_ready
o_data  output  8  payload byte
o_last  output  1  marks final payload byte of a frame
o_addr  output  8  frame ADDR byte, stable while o_valid=1
o_len  output  8  frame LEN byte, stable while o_valid=1
o_frame_ok  output  1  one-cycle pulse, frame verified
o_frame_err  output  1  one-cycle pulse, frame discarded
o_err_code  output  2  valid with o_frame_err: 1=LEN>MAX_LEN, 2=checksum mismatch, 3=timeout
o_overrun  output  1  one-cycle pulse, byte dropped because the controller was draining
o_busy  output  1  high in any state other than HUNT

Behaviour:
- Frame format: SYNC, ADDR, LEN, LEN payload bytes, CSUM. CSUM must equal the XOR of ADDR, LEN and all payload bytes.
- Reset: state=HUNT. All outputs are 0. Byte index, read index, running XOR and timeout counter are cleared. Reset overrides every state, including mid-drain. Buffer contents are don't-care after reset.
- The receiver has no backpressure. Bytes are only ever sampled on i_rx_valid.
- States:
  - HUNT: a byte equal to SYNC_BYTE moves to ADDR. Any other byte is ignored with no error.
  - ADDR: a byte latches o_addr, sets the XOR to that byte, and moves to LEN.
  - LEN: a byte latches o_len and is XORed in.
    - LEN>MAX_LEN: go to HUNT with err 1.
    - LEN=0: go to CSUM.
    - Otherwise: go to PAYLOAD.
  - PAYLOAD: each byte is written to buf[idx] and XORed in, then idx increments. After byte LEN-1, go to CSUM.
  - CSUM: if the byte equals the XOR, pulse o_frame_ok, then go to DRAIN (LEN>0) or HUNT (LEN=0). On a mismatch, go to HUNT with err 2.
  - DRAIN: o_valid=1, o_data=buf[rd_idx], o_last=(rd_idx==LEN-1).
    - On handshake, rd_idx increments.
    - On handshake with o_last=1, rd_idx clears and the state returns to HUNT; o_valid is 0 in the next cycle.
    - o_data, o_addr, o_len and o_last hold while o_valid&&!i_ready.
- Pulse timing: o_frame_ok, o_frame_err/o_err_code and o_overrun are registered. Each asserts for exactly one cycle, in the cycle after the clock edge that sampled the causing byte or timeout. o_err_code is 0 when o_frame_err=0.
- Timeout:
  - The counter runs only in ADDR, LEN, PAYLOAD and CSUM.
  - It clears on every accepted byte and on every state entry.
  - When it reaches TIMEOUT_CYCLES-1 with no byte in that cycle, go to HUNT with err 3.
  - A byte arriving in the expiry cycle wins and the timeout does not fire.
- Overrun: a byte arriving in DRAIN, including the final-handshake cycle, is dropped and pulses o_overrun. The drain continues unaffected, and a dropped SYNC_BYTE does not start a frame.
- The first o_valid appears in the cycle after the edge that accepted a good CSUM, coinciding with o_frame_ok. Throughput is 1 byte/cycle while i_ready=1.
- Widths: idx and rd_idx are $clog2(MAX_LEN+1) bits. The timeout counter is $clog2(TIMEOUT_CYCLES) bits. The XOR is 8 bits.

Test Plan:
- Good frame A5 12 03 01 02 03 11, i_ready=1 -> o_frame_ok pulse; o_data 01,02,03 on consecutive cycles; o_last only on 03; o_addr=12, o_len=03; then o_busy=0.
- Same frame with CSUM=10 -> o_frame_err with o_err_code=2; o_valid never asserts; a following good frame is accepted.
- A5 12 20 (MAX_LEN=16) -> err code 1 pulse the cycle after the LEN byte; subsequent non-A5 bytes are ignored.
- TIMEOUT_CYCLES=100: A5 12, then silence -> err code 3 exactly 100 cycles after the 12 byte. Repeat with a byte arriving on cycle 99 -> no error.
- Good frame with i_ready=0 for 20 cycles and a byte injected mid-drain -> o_overrun pulse; o_data stays 01; the full 01,02,03 stream follows once i_ready=1.
- Preamble 00 FF A5 A5 ..., and r_reset asserted mid-PAYLOAD -> the first A5 syncs (the second A5 is taken as ADDR); reset returns all outputs to 0 next cycle and state to HUNT; no pulses are emitted for the aborted frame.
